// File: rtl/pipeline_pkg.sv
// Shared definitions for the pipeline hazard controller.
package pipeline_pkg;

    localparam int unsigned PC_W  = 8;
    localparam int unsigned REG_W = 5;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_MEM_WAIT = 2'd1,
        ST_ERROR    = 2'd2
    } state_e;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with asynchronous active-low clear.
module sat_counter #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         clr_n,
    input  logic         inc,
    output logic [W-1:0] count
);

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (inc && (count_q != {W{1'b1}})) begin
            count_d = count_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count = count_q;

endmodule

// File: rtl/pipeline_hazard_unit.sv
// Stall/flush controller for the 5-stage pipeline: load-use, taken branch,
// data-memory wait freeze, plus performance counters and a sticky timeout.
module pipeline_hazard_unit #(
    parameter int unsigned PC_W        = pipeline_pkg::PC_W,
    parameter int unsigned REG_W       = pipeline_pkg::REG_W,
    parameter int unsigned CNT_W       = 16,
    parameter int unsigned MEM_TIMEOUT = 15
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] id_rs,
    input  logic [REG_W-1:0] id_rt,
    input  logic             id_uses_rt,
    input  logic             ex_memread,
    input  logic [REG_W-1:0] ex_rt,
    input  logic             mem_branch,
    input  logic             mem_zero,
    input  logic [PC_W-1:0]  mem_branch_target,
    input  logic             mem_memread,
    input  logic             mem_memwrite,
    input  logic             dmem_ready,
    output logic             pc_write,
    output logic             pc_src,
    output logic [PC_W-1:0]  pc_target,
    output logic             if_id_write,
    output logic             if_id_flush,
    output logic             id_ex_write,
    output logic             id_ex_flush,
    output logic             ex_mem_write,
    output logic             ex_mem_flush,
    output logic             mem_wb_flush,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    import pipeline_pkg::*;

    localparam int unsigned WCNT_W = $clog2(MEM_TIMEOUT + 1);

    state_e            state_q, state_d;
    logic [WCNT_W-1:0] wcnt_q, wcnt_d;
    logic              err_q, err_d;

    logic mem_op;
    logic freeze;
    logic taken;
    logic lu;

    // Hazard classification; freeze masks branch resolution, both mask load-use.
    always_comb begin
        mem_op = mem_memread | mem_memwrite;
        freeze = (mem_op & ~dmem_ready) | (state_q == ST_ERROR);
        taken  = mem_branch & mem_zero & ~freeze;
        lu     = ex_memread & (ex_rt != '0)
               & ((ex_rt == id_rs) | (id_uses_rt & (ex_rt == id_rt)))
               & ~freeze & ~taken;
    end

    // Pipeline controls; everything held inactive while reset is asserted.
    always_comb begin
        pc_write     = 1'b0;
        pc_src       = 1'b0;
        pc_target    = '0;
        if_id_write  = 1'b0;
        if_id_flush  = 1'b0;
        id_ex_write  = 1'b0;
        id_ex_flush  = 1'b0;
        ex_mem_write = 1'b0;
        ex_mem_flush = 1'b0;
        mem_wb_flush = 1'b0;
        if (reset) begin
            if (freeze) begin
                mem_wb_flush = 1'b1;
            end else if (taken) begin
                pc_write     = 1'b1;
                pc_src       = 1'b1;
                pc_target    = mem_branch_target;
                if_id_write  = 1'b1;
                if_id_flush  = 1'b1;
                id_ex_write  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_write = 1'b1;
                ex_mem_flush = 1'b1;
            end else if (lu) begin
                id_ex_write  = 1'b1;
                id_ex_flush  = 1'b1;
                ex_mem_write = 1'b1;
            end else begin
                pc_write     = 1'b1;
                if_id_write  = 1'b1;
                id_ex_write  = 1'b1;
                ex_mem_write = 1'b1;
            end
        end
    end

    // Memory-wait tracking with timeout into a sticky error state.
    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        err_d   = err_q;
        case (state_q)
            ST_RUN: begin
                if (mem_op && !dmem_ready) begin
                    state_d = ST_MEM_WAIT;
                    wcnt_d  = WCNT_W'(1);
                end
            end
            ST_MEM_WAIT: begin
                if (dmem_ready || !mem_op) begin
                    state_d = ST_RUN;
                    wcnt_d  = '0;
                end else if (wcnt_q == WCNT_W'(MEM_TIMEOUT)) begin
                    state_d = ST_ERROR;
                    err_d   = 1'b1;
                end else begin
                    wcnt_d = wcnt_q + WCNT_W'(1);
                end
            end
            ST_ERROR: begin
                err_d = 1'b1;
            end
            default: begin
                state_d = ST_RUN;
                wcnt_d  = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= ST_RUN;
            wcnt_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            err_q   <= err_d;
        end
    end

    assign mem_error = err_q;

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .clr_n (reset),
        .inc   (freeze | lu),
        .count (stall_cycles)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .clr_n (reset),
        .inc   (taken),
        .count (flush_events)
    );

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Self-checking bench for pipeline_hazard_unit: reference model feeds a scoreboard.
module tb_pipeline_hazard_unit;

    localparam int unsigned PC_W        = 8;
    localparam int unsigned REG_W       = 5;
    localparam int unsigned CNT_W       = 16;
    localparam int unsigned MEM_TIMEOUT = 15;

    logic             clk = 1'b0;
    logic             reset;
    logic [REG_W-1:0] id_rs, id_rt, ex_rt;
    logic             id_uses_rt, ex_memread;
    logic             mem_branch, mem_zero, mem_memread, mem_memwrite, dmem_ready;
    logic [PC_W-1:0]  mem_branch_target;
    logic             pc_write, pc_src, if_id_write, if_id_flush, id_ex_write, id_ex_flush;
    logic             ex_mem_write, ex_mem_flush, mem_wb_flush, mem_error;
    logic [PC_W-1:0]  pc_target;
    logic [CNT_W-1:0] stall_cycles, flush_events;

    int checks = 0;
    int errors = 0;

    int m_state;
    int m_wcnt;
    bit m_err;
    int m_stall;
    int m_flush;

    logic [16:0] exp_q[$];

    always #5 clk = ~clk;

    pipeline_hazard_unit #(
        .PC_W(PC_W), .REG_W(REG_W), .CNT_W(CNT_W), .MEM_TIMEOUT(MEM_TIMEOUT)
    ) dut (
        .clk(clk), .reset(reset),
        .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
        .ex_memread(ex_memread), .ex_rt(ex_rt),
        .mem_branch(mem_branch), .mem_zero(mem_zero),
        .mem_branch_target(mem_branch_target),
        .mem_memread(mem_memread), .mem_memwrite(mem_memwrite),
        .dmem_ready(dmem_ready),
        .pc_write(pc_write), .pc_src(pc_src), .pc_target(pc_target),
        .if_id_write(if_id_write), .if_id_flush(if_id_flush),
        .id_ex_write(id_ex_write), .id_ex_flush(id_ex_flush),
        .ex_mem_write(ex_mem_write), .ex_mem_flush(ex_mem_flush),
        .mem_wb_flush(mem_wb_flush), .mem_error(mem_error),
        .stall_cycles(stall_cycles), .flush_events(flush_events)
    );

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic logic [16:0] dut_vec();
        return {pc_write, pc_src, if_id_write, if_id_flush, id_ex_write, id_ex_flush,
                ex_mem_write, ex_mem_flush, mem_wb_flush, pc_target};
    endfunction

    task automatic idle_inputs();
        id_rs = '0; id_rt = '0; ex_rt = '0; id_uses_rt = 1'b0; ex_memread = 1'b0;
        mem_branch = 1'b0; mem_zero = 1'b0; mem_branch_target = '0;
        mem_memread = 1'b0; mem_memwrite = 1'b0; dmem_ready = 1'b0;
    endtask

    // One clock: predict, push, sample and pop, then advance the model at the edge.
    task automatic cycle();
        logic [16:0] e;
        bit mop, frz, tk, lu;
        #1;
        mop = mem_memread | mem_memwrite;
        frz = (mop && !dmem_ready) || (m_state == 2);
        tk  = mem_branch && mem_zero && !frz;
        lu  = ex_memread && (ex_rt != 5'd0) &&
              ((ex_rt == id_rs) || (id_uses_rt && (ex_rt == id_rt))) && !frz && !tk;
        if (frz)     e = {9'b000000001, 8'h00};
        else if (tk) e = {9'b111111110, mem_branch_target};
        else if (lu) e = {9'b000011100, 8'h00};
        else         e = {9'b101010100, 8'h00};
        exp_q.push_back(e);
        check_eq("ctrl", 32'(dut_vec()), 32'(exp_q.pop_front()));
        check_eq("mem_error", 32'(mem_error), 32'(m_err));
        check_eq("stall_cycles", 32'(stall_cycles), 32'(m_stall));
        check_eq("flush_events", 32'(flush_events), 32'(m_flush));
        @(posedge clk);
        if ((frz || lu) && m_stall < 65535) m_stall++;
        if (tk && m_flush < 65535) m_flush++;
        case (m_state)
            0: if (mop && !dmem_ready) begin m_state = 1; m_wcnt = 1; end
            1: begin
                if (dmem_ready || !mop) begin m_state = 0; m_wcnt = 0; end
                else if (m_wcnt == MEM_TIMEOUT) begin m_state = 2; m_err = 1'b1; end
                else m_wcnt++;
            end
            default: m_err = 1'b1;
        endcase
        #1;
    endtask

    task automatic apply_reset();
        reset = 1'b0;
        m_state = 0; m_wcnt = 0; m_err = 1'b0; m_stall = 0; m_flush = 0;
        #1;
        check_eq("rst_ctrl", 32'(dut_vec()), 32'd0);
        check_eq("rst_mem_error", 32'(mem_error), 32'd0);
        check_eq("rst_stall", 32'(stall_cycles), 32'd0);
        check_eq("rst_flush", 32'(flush_events), 32'd0);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        idle_inputs();
        apply_reset();
        cycle();

        // Load-use on rs, then the same with r0 as target (no hazard).
        ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        cycle();
        idle_inputs();
        cycle();
        check_eq("lu_stall_cnt", 32'(stall_cycles), 32'd1);
        ex_memread = 1'b1; ex_rt = 5'd0; id_rs = 5'd0;
        cycle();
        check_eq("lu_r0_nostall", 32'(stall_cycles), 32'd1);
        ex_rt = 5'd7; id_rs = 5'd1; id_rt = 5'd7; id_uses_rt = 1'b1;
        cycle();
        id_uses_rt = 1'b0;
        cycle();
        check_eq("lu_rt_cnt", 32'(stall_cycles), 32'd2);

        // Taken branch overrides a concurrent load-use.
        apply_reset();
        idle_inputs();
        ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        mem_branch = 1'b1; mem_zero = 1'b1; mem_branch_target = 8'h3C;
        #1;
        check_eq("br_pc_src", 32'(pc_src), 32'd1);
        check_eq("br_target", 32'(pc_target), 32'h3C);
        cycle();
        idle_inputs();
        cycle();
        check_eq("br_flush_cnt", 32'(flush_events), 32'd1);
        check_eq("br_no_stall", 32'(stall_cycles), 32'd0);

        // Three-cycle memory wait then completion.
        apply_reset();
        idle_inputs();
        mem_memread = 1'b1;
        repeat (3) cycle();
        dmem_ready = 1'b1;
        cycle();
        idle_inputs();
        cycle();
        check_eq("mw_stall_cnt", 32'(stall_cycles), 32'd3);
        check_eq("mw_back_run", 32'(pc_write), 32'd1);

        // Single-cycle access: no stall.
        mem_memwrite = 1'b1; dmem_ready = 1'b1;
        cycle();
        check_eq("single_cycle_nostall", 32'(stall_cycles), 32'd3);

        // Freeze masks a branch until the memory completes.
        apply_reset();
        idle_inputs();
        mem_branch = 1'b1; mem_zero = 1'b1; mem_branch_target = 8'h3C; mem_memread = 1'b1;
        repeat (2) cycle();
        check_eq("frz_br_pc_src", 32'(pc_src), 32'd0);
        dmem_ready = 1'b1;
        #1;
        check_eq("frz_br_release", 32'(pc_src), 32'd1);
        cycle();

        // Reset in the middle of a memory wait.
        idle_inputs();
        mem_memread = 1'b1;
        repeat (2) cycle();
        apply_reset();
        idle_inputs();
        cycle();

        // Timeout into sticky error, then recovery through reset.
        mem_memwrite = 1'b1;
        repeat (MEM_TIMEOUT) cycle();
        check_eq("to_not_yet", 32'(mem_error), 32'd0);
        cycle();
        check_eq("to_error", 32'(mem_error), 32'd1);
        idle_inputs();
        dmem_ready = 1'b1;
        repeat (3) cycle();
        check_eq("to_sticky_freeze", 32'(pc_write), 32'd0);
        apply_reset();
        idle_inputs();
        cycle();

        // Random traffic against the model.
        for (int i = 0; i < 400; i++) begin
            id_rs = REG_W'($urandom_range(0, 3));
            id_rt = REG_W'($urandom_range(0, 3));
            ex_rt = REG_W'($urandom_range(0, 3));
            id_uses_rt = 1'($urandom);
            ex_memread = 1'($urandom);
            mem_branch = 1'($urandom);
            mem_zero = 1'($urandom);
            mem_branch_target = PC_W'($urandom);
            mem_memread = ($urandom_range(0, 3) == 0);
            mem_memwrite = ($urandom_range(0, 5) == 0);
            dmem_ready = ($urandom_range(0, 3) != 0);
            cycle();
            if (i == 200) apply_reset();
        end

        // Stall counter saturation.
        apply_reset();
        idle_inputs();
        ex_memread = 1'b1; ex_rt = 5'd5; id_rs = 5'd5;
        repeat (65540) cycle();
        check_eq("stall_saturated", 32'(stall_cycles), 32'hFFFF);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_unit.md
Name: pipeline_hazard_unit

Overview:
Central stall/flush controller for the 5-stage pipeline.
- Detects load-use hazards between the ID and EX stages.
- Resolves taken branches presented by the EX/MEM register.
- Freezes the pipeline while data memory is busy.
- Drives the write-enable/flush controls of PC, IF/ID, ID/EX, EX/MEM and MEM/WB.
- Keeps saturating stall/flush performance counters and a sticky memory-timeout error.

Parameters:
PC_W, 8, width of branch target / PC (matches EX/MEM branch target field)
REG_W, 5, register specifier width
CNT_W, 16, performance counter width
MEM_TIMEOUT, 15, max consecutive dmem wait cycles before error

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
id_rs  in  REG_W  source reg 1 of instruction in ID
id_rt  in  REG_W  source reg 2 of instruction in ID
id_uses_rt  in  1  ID instruction reads rt
ex_memread  in  1  ID/EX MemRead output
ex_rt  in  REG_W  ID/EX destination (load target) register
mem_branch  in  1  EX/MEM branch flag
mem_zero  in  1  EX/MEM zero flag
mem_branch_target  in  PC_W  EX/MEM branch target
mem_memread  in  1  EX/MEM MemRead output
mem_memwrite  in  1  EX/MEM MemWrite output
dmem_ready  in  1  data memory completes access this cycle
pc_write  out  1  PC load enable
pc_src  out  1  select branch target for PC
pc_target  out  PC_W  branch target to PC mux
if_id_write  out  1  IF/ID load enable
if_id_flush  out  1  IF/ID clear to bubble
id_ex_write  out  1  ID/EX load enable
id_ex_flush  out  1  ID/EX clear to bubble
ex_mem_write  out  1  EX/MEM load enable
ex_mem_flush  out  1  EX/MEM clear to bubble
mem_wb_flush  out  1  MEM/WB clear to bubble
mem_error  out  1  sticky dmem timeout
stall_cycles  out  CNT_W  saturating count of stalled cycles
flush_events  out  CNT_W  saturating count of taken-branch flushes

Behaviour:
- Internal states: RUN, MEM_WAIT, ERROR. Internal wait counter wcnt, width clog2(MEM_TIMEOUT+1).

Reset (reset=0, async):
- state=RUN, wcnt=0, mem_error=0, counters=0.
- Combinational outputs forced: all *_write=0, all *_flush=0, pc_src=0, pc_target=0.

Derived signals:
- mem_op = mem_memread | mem_memwrite.
- freeze = mem_op & ~dmem_ready, or state==ERROR.
- taken = mem_branch & mem_zero & ~freeze.
- lu = ex_memread & (ex_rt!=0) & ((ex_rt==id_rs) | (id_uses_rt & ex_rt==id_rt)) & ~freeze & ~taken.

Outputs (combinational, priority freeze > taken > lu > normal):
- freeze: pc/if_id/id_ex/ex_mem write=0; mem_wb_flush=1; other flushes=0.
- taken: all writes=1; pc_src=1; pc_target=mem_branch_target; if_id_flush=id_ex_flush=ex_mem_flush=1.
- lu: pc_write=if_id_write=0; id_ex_flush=1; id_ex_write=ex_mem_write=1.
- normal: all writes=1, all flushes=0, pc_src=0.
- pc_target=mem_branch_target whenever taken, else 0.

FSM (rising edge):
- RUN: if mem_op & ~dmem_ready -> MEM_WAIT, wcnt=1; else stay.
- MEM_WAIT:
  - dmem_ready=1 -> RUN, wcnt=0. The branch in EX/MEM may resolve that same cycle.
  - ~mem_op (access withdrawn) -> RUN.
  - wcnt==MEM_TIMEOUT with ~dmem_ready -> ERROR, mem_error=1.
  - otherwise wcnt+1.
- ERROR: permanent freeze until reset; mem_error stays 1.

Counters:
- stall_cycles +1 each cycle freeze|lu is true; saturates at all-ones.
- flush_events +1 each cycle taken is true; saturates at all-ones.
- Single-cycle dmem access (dmem_ready=1 in the same cycle as mem_op): no stall, no state change.
- Reset asserted mid-MEM_WAIT: immediate return to RUN, counters cleared.

Decomposition:
- Shared package pipeline_pkg:
  - State encoding (RUN=2'd0, MEM_WAIT=2'd1, ERROR=2'd2).
  - PC_W and REG_W constants.
- One sub-module: sat_counter (CNT_W wide, inc enable, async active-low clear). Instantiated twice for stall_cycles and flush_events.

Test Plan:
- Load-use: ex_memread=1, ex_rt=5, id_rs=5 -> pc_write=0, if_id_write=0, id_ex_flush=1 for 1 cycle; stall_cycles=1. Same with ex_rt=0 -> no stall.
- Taken branch: mem_branch=1, mem_zero=1, mem_branch_target=8'h3C, plus a concurrent load-use -> pc_src=1, pc_target=8'h3C, three flushes=1, no stall; flush_events=1.
- Memory wait: mem_memread=1, dmem_ready=0 for 3 cycles then 1 -> freeze for exactly 3 cycles with mem_wb_flush=1; RUN afterwards; stall_cycles=3.
- Timeout: dmem_ready held 0 with mem_memwrite=1 -> mem_error=1 after MEM_TIMEOUT=15 wait cycles, freeze sticky; reset low -> mem_error=0, counters 0.
- Freeze over branch: mem_branch=mem_zero=1, mem_memread=1, dmem_ready=0 -> pc_src=0 until dmem_ready=1, then pc_src=1 that cycle.
- Saturation: force 65536+ stalled cycles -> stall_cycles holds 16'hFFFF.
